lcd_frame_scanner: RTL and testbench



---
 rtl/lcd_pkg.sv | 25 ++
 rtl/lcd_pix_mux.sv | 23 ++
 rtl/lcd_frame_scanner.sv | 133 +++++++++++++
 tb/tb_lcd_frame_scanner.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD frame scanner and its pixel datapath.
package lcd_pkg;

    localparam int unsigned RGB_W     = 16;
    localparam int unsigned LCD_H_RES = 240;
    localparam int unsigned LCD_V_RES = 240;
    localparam int unsigned ROM_ROW_W = 240;
    localparam int unsigned COL_W     = 8;

    typedef logic [RGB_W-1:0] rgb565_t;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StAddr   = 3'd1,
        StLoad   = 3'd2,
        StStream = 3'd3,
        StDone   = 3'd4
    } lcd_state_e;

    function automatic rgb565_t pick_color(input logic bit_val, input rgb565_t fg,
                                           input rgb565_t bg);
        return bit_val ? fg : bg;
    endfunction

endpackage

// File: rtl/lcd_pix_mux.sv
// Bitmap-to-colour pixel selector: picks one bit of a row and expands it to RGB565.
module lcd_pix_mux
    import lcd_pkg::*;
(
    input  logic [ROM_ROW_W-1:0] bits,
    input  logic [COL_W-1:0]     idx,
    input  logic [RGB_W-1:0]     fg,
    input  logic [RGB_W-1:0]     bg,
    output logic [RGB_W-1:0]     pix
);

    logic sel;

    always_comb begin
        sel = 1'b0;
        // Out-of-row indices fall back to background rather than reading past the bitmap.
        if (32'(idx) < ROM_ROW_W) begin
            sel = bits[idx];
        end
        pix = pick_color(sel, fg, bg);
    end

endmodule

// File: rtl/lcd_frame_scanner.sv
// Scans a frame row by row from the sprite ROM and streams RGB565 pixels over valid/ready.
module lcd_frame_scanner
    import lcd_pkg::*;
#(
    parameter int unsigned H_RES  = LCD_H_RES,
    parameter int unsigned V_RES  = LCD_V_RES,
    parameter int unsigned ADDR_W = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [RGB_W-1:0]     fg_color,
    input  logic [RGB_W-1:0]     bg_color,
    output logic [ADDR_W-1:0]    row_addr,
    input  logic [ROM_ROW_W-1:0] row_bits,
    output logic [RGB_W-1:0]     pix_data,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic                 pix_sof,
    output logic                 pix_eol,
    output logic                 busy,
    output logic                 frame_done
);

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(H_RES - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(V_RES - 1);

    lcd_state_e           state_q;
    logic [RGB_W-1:0]     fg_q;
    logic [RGB_W-1:0]     bg_q;
    logic [ROM_ROW_W-1:0] row_q;
    logic [COL_W-1:0]     col_q;

    logic                 accept;
    logic [COL_W-1:0]     col_next;
    logic [ROM_ROW_W-1:0] mux_bits;
    logic [COL_W-1:0]     mux_idx;
    logic [RGB_W-1:0]     mux_pix;

    assign accept = pix_valid && pix_ready;

    // In LOAD the row register is not yet written, so column 0 comes straight from the ROM.
    always_comb begin
        col_next = col_q + COL_W'(1);
        mux_bits = row_q;
        mux_idx  = col_next;
        if (state_q == StLoad) begin
            mux_bits = row_bits;
            mux_idx  = '0;
        end
    end

    lcd_pix_mux u_pix_mux (
        .bits (mux_bits),
        .idx  (mux_idx),
        .fg   (fg_q),
        .bg   (bg_q),
        .pix  (mux_pix)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            fg_q       <= '0;
            bg_q       <= '0;
            row_q      <= '0;
            col_q      <= '0;
            row_addr   <= '0;
            pix_data   <= '0;
            pix_valid  <= 1'b0;
            pix_sof    <= 1'b0;
            pix_eol    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        fg_q     <= fg_color;
                        bg_q     <= bg_color;
                        row_addr <= '0;
                        col_q    <= '0;
                        busy     <= 1'b1;
                        state_q  <= StAddr;
                    end
                end
                StAddr: begin
                    state_q <= StLoad;
                end
                StLoad: begin
                    row_q     <= row_bits;
                    col_q     <= '0;
                    pix_data  <= mux_pix;
                    pix_valid <= 1'b1;
                    pix_sof   <= (row_addr == '0);
                    pix_eol   <= (COL_LAST == '0);
                    state_q   <= StStream;
                end
                StStream: begin
                    if (accept) begin
                        if (col_q < COL_LAST) begin
                            col_q    <= col_next;
                            pix_data <= mux_pix;
                            pix_sof  <= 1'b0;
                            pix_eol  <= (col_next == COL_LAST);
                        end else begin
                            pix_valid <= 1'b0;
                            pix_sof   <= 1'b0;
                            pix_eol   <= 1'b0;
                            if (row_addr < ROW_LAST) begin
                                row_addr <= row_addr + ADDR_W'(1);
                                state_q  <= StAddr;
                            end else begin
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
                                state_q    <= StDone;
                            end
                        end
                    end
                end
                StDone: begin
                    col_q   <= '0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_frame_scanner.sv
// Self-checking bench: full-size frame on one scanner, backpressure/reset/start filtering on a small one.
module tb_lcd_frame_scanner;

    localparam int HB  = 16;
    localparam int VB  = 12;
    localparam int AWB = 4;
    localparam logic [239:0] ROW1_PAT = 240'h060;

    typedef struct packed {
        logic [15:0] data;
        logic        sof;
        logic        eol;
        logic [8:0]  row;
    } beat_t;

    typedef struct packed {
        logic        valid;
        logic        busy;
        logic        sof;
        logic [15:0] data;
    } lat_t;

    typedef struct packed {
        logic [15:0] fg;
        logic [15:0] bg;
        logic [7:0]  pct;
        logic        stall;
        logic        mid;
    } frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_a, rst_b, start_a, start_b, pix_ready, hold_low;
    logic [15:0] fg, bg;
    int ready_pct = 100;

    logic [8:0]   ra_a;
    logic [239:0] bits_a;
    logic [15:0]  pd_a;
    logic         pv_a, ps_a, pe_a, busy_a, fd_a;

    logic [AWB-1:0] ra_b;
    logic [239:0]   bits_b;
    logic [15:0]    pd_b;
    logic           pv_b, ps_b, pe_b, busy_b, fd_b;
    logic [239:0]   rom_b [16];

    assign bits_a = (ra_a == 9'd1) ? ROW1_PAT : '0;
    assign bits_b = rom_b[ra_b];

    lcd_frame_scanner u_dut_a (
        .clk        (clk),
        .rst        (rst_a),
        .start      (start_a),
        .fg_color   (fg),
        .bg_color   (bg),
        .row_addr   (ra_a),
        .row_bits   (bits_a),
        .pix_data   (pd_a),
        .pix_valid  (pv_a),
        .pix_ready  (pix_ready),
        .pix_sof    (ps_a),
        .pix_eol    (pe_a),
        .busy       (busy_a),
        .frame_done (fd_a)
    );

    lcd_frame_scanner #(
        .H_RES  (HB),
        .V_RES  (VB),
        .ADDR_W (AWB)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst_b),
        .start      (start_b),
        .fg_color   (fg),
        .bg_color   (bg),
        .row_addr   (ra_b),
        .row_bits   (bits_b),
        .pix_data   (pd_b),
        .pix_valid  (pv_b),
        .pix_ready  (pix_ready),
        .pix_sof    (ps_b),
        .pix_eol    (pe_b),
        .busy       (busy_b),
        .frame_done (fd_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the expected beat sequence of a whole frame, straight from the pixel rule.
    beat_t exp_a[$];
    beat_t exp_b[$];

    function automatic logic rom_bit_a(input int y, input int x);
        return (y == 1) && (x == 5 || x == 6);
    endfunction

    task automatic build_exp_a(input logic [15:0] f, input logic [15:0] b);
        beat_t e;
        exp_a.delete();
        for (int y = 0; y < 240; y++) begin
            for (int x = 0; x < 240; x++) begin
                e.data = rom_bit_a(y, x) ? f : b;
                e.sof  = (x == 0) && (y == 0);
                e.eol  = (x == 239);
                e.row  = 9'(y);
                exp_a.push_back(e);
            end
        end
    endtask

    task automatic build_exp_b(input logic [15:0] f, input logic [15:0] b);
        beat_t e;
        logic [239:0] r;
        exp_b.delete();
        for (int y = 0; y < VB; y++) begin
            r = rom_b[y];
            for (int x = 0; x < HB; x++) begin
                e.data = r[x] ? f : b;
                e.sof  = (x == 0) && (y == 0);
                e.eol  = (x == HB - 1);
                e.row  = 9'(y);
                exp_b.push_back(e);
            end
        end
    endtask

    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            pix_ready = hold_low ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Monitor for the full-size scanner.
    int beats_a = 0, eols_a = 0, fd_cnt_a = 0, last_acc_a = 0;
    logic stall_a = 1'b0, last_eol_a = 1'b0;
    logic [17:0] hold_a;
    logic [8:0] prev_ra_a;

    always @(negedge clk) begin
        beat_t e;
        if (rst_a) begin
            exp_a.delete();
            last_eol_a = 1'b0;
        end else begin
            if (stall_a) check("a_stall_hold", {pv_a, ps_a, pe_a, pd_a}, {1'b1, hold_a});
            if (ra_a != prev_ra_a)
                check("a_row_step", ra_a, last_eol_a ? prev_ra_a + 9'd1 : 9'd0);
            if (pv_a && pix_ready) begin
                if (exp_a.size() == 0) begin
                    check("a_extra_beat", exp_a.size(), 1);
                end else begin
                    e = exp_a.pop_front();
                    check("a_beat", {pd_a, ps_a, pe_a, ra_a, busy_a}, {e, 1'b1});
                end
                beats_a++;
                if (pe_a) eols_a++;
                last_acc_a = cyc;
                last_eol_a = pe_a;
            end
            if (fd_a) begin
                fd_cnt_a++;
                last_eol_a = 1'b0;
                check("a_done_timing", cyc - last_acc_a, 1);
                check("a_done_busy", busy_a, 0);
                check("a_queue_drained", exp_a.size(), 0);
            end
        end
        stall_a   = !rst_a && pv_a && !pix_ready;
        hold_a    = {ps_a, pe_a, pd_a};
        prev_ra_a = ra_a;
    end

    // Monitor for the small scanner.
    int beats_b = 0, eols_b = 0, fd_cnt_b = 0, last_acc_b = 0;
    logic stall_b = 1'b0, last_eol_b = 1'b0;
    logic [17:0] hold_b;
    logic [AWB-1:0] prev_ra_b;

    always @(negedge clk) begin
        beat_t e;
        if (rst_b) begin
            exp_b.delete();
            last_eol_b = 1'b0;
        end else begin
            if (stall_b) check("b_stall_hold", {pv_b, ps_b, pe_b, pd_b}, {1'b1, hold_b});
            if (ra_b != prev_ra_b)
                check("b_row_step", ra_b, last_eol_b ? prev_ra_b + 4'd1 : 4'd0);
            if (pv_b && pix_ready) begin
                if (exp_b.size() == 0) begin
                    check("b_extra_beat", exp_b.size(), 1);
                end else begin
                    e = exp_b.pop_front();
                    check("b_beat", {pd_b, ps_b, pe_b, 5'd0, ra_b, busy_b}, {e, 1'b1});
                end
                beats_b++;
                if (pe_b) eols_b++;
                last_acc_b = cyc;
                last_eol_b = pe_b;
            end
            if (fd_b) begin
                fd_cnt_b++;
                last_eol_b = 1'b0;
                check("b_done_timing", cyc - last_acc_b, 1);
                check("b_done_busy", busy_b, 0);
                check("b_queue_drained", exp_b.size(), 0);
            end
        end
        stall_b   = !rst_b && pv_b && !pix_ready;
        hold_b    = {ps_b, pe_b, pd_b};
        prev_ra_b = ra_b;
    end

    task automatic randomize_rom_b();
        for (int i = 0; i < 16; i++) rom_b[i] = 240'($urandom());
    endtask

    task automatic wait_row_b(input int r);
        int n = 0;
        while (!(ra_b == AWB'(r) && pv_b) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("b_row_reached", n < 5000, 1);
        tick();
    endtask

    task automatic run_frame_b(input frame_t fr);
        int fd0, beats0, eols0, n;
        fd0    = fd_cnt_b;
        beats0 = beats_b;
        eols0  = eols_b;
        randomize_rom_b();
        fg        = fr.fg;
        bg        = fr.bg;
        ready_pct = int'(fr.pct);
        build_exp_b(fr.fg, fr.bg);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        if (fr.stall) begin
            wait_row_b(3);
            tick();
            hold_low = 1'b1;
            repeat (10) tick();
            hold_low = 1'b0;
        end
        if (fr.mid) begin
            wait_row_b(6);
            fg      = 16'h07E0;
            bg      = ~fr.bg;
            start_b = 1'b1;
            tick();
            start_b = 1'b0;
        end
        n = 0;
        while (!fd_b && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("b_done_seen", n < 5000, 1);
        if (fr.mid) start_b = 1'b1;  // lands in the DONE cycle and must be dropped
        tick();
        start_b = 1'b0;
        repeat (3) tick();
        check("b_idle_after_done", {busy_b, pv_b}, 0);
        check("b_done_count", fd_cnt_b - fd0, 1);
        check("b_beat_count", beats_b - beats0, HB * VB);
        check("b_eol_count", eols_b - eols0, VB);
    endtask

    lat_t   lat [4];
    frame_t frames [4];

    initial begin
        int n, fd0;

        lat[0] = '{valid: 1'b0, busy: 1'b0, sof: 1'b0, data: 16'h0000};
        lat[1] = '{valid: 1'b0, busy: 1'b1, sof: 1'b0, data: 16'h0000};
        lat[2] = '{valid: 1'b0, busy: 1'b1, sof: 1'b0, data: 16'h0000};
        lat[3] = '{valid: 1'b1, busy: 1'b1, sof: 1'b1, data: 16'h001F};

        frames[0] = '{fg: 16'hF800, bg: 16'h001F, pct: 8'd100, stall: 1'b0, mid: 1'b0};
        frames[1] = '{fg: 16'hF800, bg: 16'h001F, pct: 8'd50,  stall: 1'b1, mid: 1'b0};
        frames[2] = '{fg: 16'hF800, bg: 16'h001F, pct: 8'd70,  stall: 1'b0, mid: 1'b1};
        frames[3] = '{fg: 16'($urandom()), bg: 16'($urandom()), pct: 8'd30,
                      stall: 1'b1, mid: 1'b1};

        rst_a    = 1'b1;
        rst_b    = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        hold_low = 1'b0;
        fg       = 16'h0;
        bg       = 16'h0;
        randomize_rom_b();
        repeat (3) tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();

        check("a_reset_state", {ra_a, pd_a, pv_a, ps_a, pe_a, busy_a, fd_a}, 0);
        check("b_reset_state", {ra_b, pd_b, pv_b, ps_b, pe_b, busy_b, fd_b}, 0);

        // Full-size frame: latency, pixel map, counts, row stepping.
        fg = 16'hF800;
        bg = 16'h001F;
        ready_pct = 100;
        build_exp_a(fg, bg);
        start_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("a_latency", {pv_a, busy_a, ps_a, pd_a}, lat[k]);
            tick();
            start_a = 1'b0;
        end
        n = 0;
        while (!fd_a && n < 70000) begin
            @(negedge clk);
            n++;
        end
        check("a_done_seen", n < 70000, 1);
        @(negedge clk);
        check("a_done_single", {fd_a, busy_a, pv_a}, 0);
        check("a_done_count", fd_cnt_a, 1);
        check("a_beat_count", beats_a, 57600);
        check("a_eol_count", eols_a, 240);
        check("a_last_row", ra_a, 239);
        tick();

        // Small scanner: backpressure, colour latch and start filtering.
        for (int i = 0; i < 4; i++) run_frame_b(frames[i]);

        // Mid-frame reset, then a clean frame.
        randomize_rom_b();
        fg = 16'h1234;
        bg = 16'hABCD;
        ready_pct = 100;
        build_exp_b(fg, bg);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        wait_row_b(5);
        repeat (3) tick();
        check("b_rst_pre_valid", {busy_b, pv_b}, 2'b11);
        fd0   = fd_cnt_b;
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        @(negedge clk);
        check("b_rst_state", {pv_b, busy_b, ra_b, pd_b, ps_b, pe_b, fd_b}, 0);
        repeat (20) tick();
        check("b_rst_no_done", fd_cnt_b - fd0, 0);
        run_frame_b(frames[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
